multimode_counter: RTL and testbench

- Parametrised successor to the team's fixed 4-bit up counter.
- Provides a WIDTH-bit register that steps in one of four runtime-selectable modes: binary up, binary down, ring (one-hot rotate) and Johnson (twisted ring).
- Adds count enable, synchronous parallel load, a programmable binary terminal value, a registered wrap pulse and a combinational terminal-state flag.
- Used as a general timebase, sequencer or phase generator in the sequential library.

---
 rtl/multimode_counter.sv | 107 ++++++++++
 tb/tb_multimode_counter.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/multimode_counter.sv
// WIDTH-bit counter with four runtime modes: binary up/down, one-hot ring and Johnson.
// Provides parallel load, a programmable binary terminal value, a registered wrap pulse and a terminal-state flag.
module multimode_counter #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] MAX_VAL   = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             at_term
);

  typedef enum logic [1:0] {
    MODE_UP      = 2'b00,
    MODE_DOWN    = 2'b01,
    MODE_RING    = 2'b10,
    MODE_JOHNSON = 2'b11
  } mode_t;

  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;
  logic             wrap_reg;
  logic             wrap_next;
  logic [WIDTH-1:0] ring_shift;
  logic [WIDTH-1:0] johnson_shift;
  logic             is_onehot;

  // Ring and Johnson share the left shift; they differ only in the bit fed back into bit 0.
  assign ring_shift[0]    = count_reg[WIDTH-1];
  assign johnson_shift[0] = ~count_reg[WIDTH-1];

  generate
    for (genvar gi = 1; gi < WIDTH; gi++) begin : g_shift
      assign ring_shift[gi]    = count_reg[gi-1];
      assign johnson_shift[gi] = count_reg[gi-1];
    end
  endgenerate

  assign is_onehot = (count_reg != '0) && ((count_reg & (count_reg - ONE)) == '0);

  // wrap_next is the step outcome regardless of en/load, so it doubles as the terminal-state flag.
  always_comb begin
    count_next = count_reg;
    wrap_next  = 1'b0;
    case (mode_t'(mode))
      MODE_UP: begin
        if (count_reg >= MAX_VAL) begin
          count_next = '0;
          wrap_next  = 1'b1;
        end else begin
          count_next = count_reg + ONE;
        end
      end
      MODE_DOWN: begin
        if (count_reg == '0) begin
          count_next = MAX_VAL;
          wrap_next  = 1'b1;
        end else if (count_reg > MAX_VAL) begin
          count_next = MAX_VAL;
        end else begin
          count_next = count_reg - ONE;
        end
      end
      MODE_RING: begin
        if (!is_onehot) begin
          count_next = ONE;
        end else begin
          count_next = ring_shift;
          wrap_next  = (count_reg == MSB_ONLY);
        end
      end
      default: begin
        count_next = johnson_shift;
        wrap_next  = (count_reg == MSB_ONLY);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= RESET_VAL;
      wrap_reg  <= 1'b0;
    end else if (load) begin
      count_reg <= load_val;
      wrap_reg  <= 1'b0;
    end else if (en) begin
      count_reg <= count_next;
      wrap_reg  <= wrap_next;
    end else begin
      wrap_reg  <= 1'b0;
    end
  end

  assign count   = count_reg;
  assign wrap    = wrap_reg;
  assign at_term = wrap_next;

endmodule

// File: tb/tb_multimode_counter.sv
// Scoreboard bench for multimode_counter (WIDTH=4, MAX_VAL=9): stimulus pushes expected
// results into a queue and an independent monitor pops and compares them each cycle.
module tb_multimode_counter;

  logic       clk;
  logic       reset;
  logic       en;
  logic [1:0] mode;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] count;
  logic       wrap;
  logic       at_term;

  typedef struct {
    string      name;
    logic [3:0] exp_count;
    logic       exp_wrap;
    logic       exp_term;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  multimode_counter #(
    .WIDTH    (4),
    .MAX_VAL  (4'd9),
    .RESET_VAL(4'd0)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .mode    (mode),
    .load    (load),
    .load_val(load_val),
    .count   (count),
    .wrap    (wrap),
    .at_term (at_term)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: outputs settle after the rising edge; compare on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (count !== e.exp_count || wrap !== e.exp_wrap || at_term !== e.exp_term) begin
        failures++;
        $display("FAIL %s: count=%h wrap=%b at_term=%b, required count=%h wrap=%b at_term=%b",
                 e.name, count, wrap, at_term, e.exp_count, e.exp_wrap, e.exp_term);
      end else begin
        $display("ok   %s: count=%h wrap=%b at_term=%b", e.name, count, wrap, at_term);
      end
    end
  end

  // Drive one cycle of inputs, then enqueue the hand-computed result of that edge.
  task automatic step(input string name, input logic r, input logic ld, input logic e,
                      input logic [1:0] m, input logic [3:0] lv,
                      input logic [3:0] ec, input logic ew, input logic et);
    exp_t x;
    reset    = r;
    load     = ld;
    en       = e;
    mode     = m;
    load_val = lv;
    @(posedge clk);
    #1;
    x.name      = name;
    x.exp_count = ec;
    x.exp_wrap  = ew;
    x.exp_term  = et;
    exp_q.push_back(x);
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] jseq [16];
    logic [3:0] c;
    jseq = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0,
             4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0};
    reset = 1'b1; load = 1'b0; en = 1'b0; mode = 2'b00; load_val = 4'd0;
    @(negedge clk);
    #1;

    step("reset", 1, 0, 0, 2'b00, 4'd0, 4'd0, 0, 0);

    // Up mode, 25 steps: 1..9,0..9,0..5
    for (int k = 1; k <= 25; k++) begin
      c = 4'(k % 10);
      step("up", 0, 0, 1, 2'b00, 4'd0, c, c == 4'd0, c == 4'd9);
    end

    // Reset mid-count at 6, then resume
    step("up_to_6", 0, 0, 1, 2'b00, 4'd0, 4'd6, 0, 0);
    step("reset_mid", 1, 0, 1, 2'b00, 4'd0, 4'd0, 0, 0);
    step("resume", 0, 0, 1, 2'b00, 4'd0, 4'd1, 0, 0);

    // Down mode from 0: 9,8..0,9
    step("down_load0", 0, 1, 1, 2'b01, 4'd0, 4'd0, 0, 1);
    for (int j = 0; j <= 10; j++) begin
      c = (j == 10) ? 4'd9 : 4'(9 - j);
      step("down", 0, 0, 1, 2'b01, 4'd0, c, c == 4'd9, c == 4'd0);
    end
    step("down_load12", 0, 1, 0, 2'b01, 4'd12, 4'd12, 0, 0);
    step("down_clamp", 0, 0, 1, 2'b01, 4'd0, 4'd9, 0, 0);

    // Up mode above MAX_VAL wraps to 0
    step("up_load12", 0, 1, 0, 2'b00, 4'd12, 4'd12, 0, 1);
    step("up_over_wrap", 0, 0, 1, 2'b00, 4'd0, 4'd0, 1, 0);

    // Ring mode
    step("ring_load0", 0, 1, 0, 2'b10, 4'd0, 4'd0, 0, 0);
    step("ring_recover", 0, 0, 1, 2'b10, 4'd0, 4'd1, 0, 0);
    step("ring", 0, 0, 1, 2'b10, 4'd0, 4'd2, 0, 0);
    step("ring", 0, 0, 1, 2'b10, 4'd0, 4'd4, 0, 0);
    step("ring", 0, 0, 1, 2'b10, 4'd0, 4'd8, 0, 1);
    step("ring_wrap", 0, 0, 1, 2'b10, 4'd0, 4'd1, 1, 0);
    step("ring_load5", 0, 1, 0, 2'b10, 4'd5, 4'd5, 0, 0);
    step("ring_recover5", 0, 0, 1, 2'b10, 4'd0, 4'd1, 0, 0);

    // Johnson mode from 0, 16 steps
    step("john_load0", 0, 1, 0, 2'b11, 4'd0, 4'd0, 0, 0);
    for (int k = 0; k < 16; k++) begin
      step("johnson", 0, 0, 1, 2'b11, 4'd0, jseq[k], jseq[k] == 4'h0, jseq[k] == 4'h8);
    end

    // Priority and hold
    step("load_over_en", 0, 1, 1, 2'b00, 4'd5, 4'd5, 0, 0);
    step("reset_over_load", 1, 1, 1, 2'b00, 4'd7, 4'd0, 0, 0);
    step("up_load9", 0, 1, 0, 2'b00, 4'd9, 4'd9, 0, 1);
    step("up_wrap9", 0, 0, 1, 2'b00, 4'd0, 4'd0, 1, 0);
    step("hold_clr_wrap", 0, 0, 0, 2'b00, 4'd0, 4'd0, 0, 0);
    step("hold", 0, 0, 0, 2'b00, 4'd3, 4'd0, 0, 0);

    // Mode change reinterprets the count; at_term ignores en
    step("up_load6", 0, 1, 0, 2'b00, 4'd6, 4'd6, 0, 0);
    step("up_to_ring", 0, 0, 1, 2'b10, 4'd0, 4'd1, 0, 0);
    step("john_load8", 0, 1, 0, 2'b11, 4'd8, 4'd8, 0, 1);
    step("john_hold8", 0, 0, 0, 2'b11, 4'd0, 4'd8, 0, 1);

    for (int w = 0; w < 20 && exp_q.size() > 0; w++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain: pending=%0d, required pending=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
